// File: rtl/value_match_classifier.sv
// value_match_classifier
// Two-stage priority classifier. Stage 1 captures the per-entry equality
// vector of an accepted value against a programmable constant table.
// Stage 2 encodes it into hit / lowest-index / multiple-match results.
// A saturating counter tallies delivered results that matched two or more
// entries. Ready/valid handshakes on both sides; at most two values in flight.
module value_match_classifier #(
  parameter int WIDTH       = 32,
  parameter int NUM_ENTRIES = 12,
  parameter int IDX_W       = 4,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_addr,
  input  logic [WIDTH-1:0] cfg_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_value,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_hit,
  output logic [IDX_W-1:0] out_index,
  output logic             out_multi,
  output logic [CNT_W-1:0] multi_count
);

  // Match constant table; each entry resets to its own index plus one.
  logic [WIDTH-1:0]       entry_reg [NUM_ENTRIES];

  // Equality of the incoming value against every entry (pre-write contents).
  logic [NUM_ENTRIES-1:0] match_vec;

  // Stage 1: captured match vector.
  logic                   s1_valid;
  logic [NUM_ENTRIES-1:0] s1_vec;

  // Pipeline control.
  logic                   accept;
  logic                   s2_advance;

  // Stage 2 encoder results (combinational from stage 1).
  logic                   enc_hit;
  logic [IDX_W-1:0]       enc_idx;
  logic                   enc_multi;

  // Stage 2 may load when it is empty or its current result is being taken.
  assign s2_advance = !out_valid || out_ready;
  // Stage 1 frees up when empty or when it moves into stage 2 this edge.
  assign in_ready   = !s1_valid || s2_advance;
  assign accept     = in_valid && in_ready;

  // One comparator per table entry.
  for (genvar gi = 0; gi < NUM_ENTRIES; gi++) begin : g_match
    assign match_vec[gi] = (in_value == entry_reg[gi]);
  end

  // Table storage: reset to 1..NUM_ENTRIES, out-of-range write addresses
  // decode to no entry and are therefore ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        entry_reg[i] <= WIDTH'(i + 1);
      end
    end else begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        if (cfg_we && (cfg_addr == IDX_W'(i))) begin
          entry_reg[i] <= cfg_data;
        end
      end
    end
  end

  // Stage 1 register: capture the match vector on an input handshake; the
  // slot stays occupied while stage 2 is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_vec   <= '0;
    end else begin
      s1_valid <= accept || (s1_valid && !s2_advance);
      if (accept) begin
        s1_vec <= match_vec;
      end
    end
  end

  // Priority encoder: scanning downwards leaves the lowest set index. Two or
  // more bits set is detected by clearing the lowest set bit.
  always_comb begin
    enc_hit   = |s1_vec;
    enc_idx   = '0;
    enc_multi = |(s1_vec & (s1_vec - NUM_ENTRIES'(1)));
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (s1_vec[i]) begin
        enc_idx = IDX_W'(i);
      end
    end
  end

  // Stage 2 register: result outputs hold while the consumer stalls; an
  // empty stage presents all-zero results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_hit   <= 1'b0;
      out_index <= '0;
      out_multi <= 1'b0;
    end else if (s2_advance) begin
      out_valid <= s1_valid;
      out_hit   <= s1_valid && enc_hit;
      out_index <= s1_valid ? enc_idx : '0;
      out_multi <= s1_valid && enc_multi;
    end
  end

  // Saturating count of delivered multiple-match results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      multi_count <= '0;
    end else if (out_valid && out_ready && out_multi && (multi_count != {CNT_W{1'b1}})) begin
      multi_count <= multi_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_value_match_classifier.sv
// Testbench for value_match_classifier: randomized and directed stimulus
// against a transaction-level reference model (table copy + in-flight queue).
module tb_value_match_classifier;
  localparam int W  = 32;
  localparam int N  = 12;
  localparam int IW = 4;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_we = 1'b0;
  logic [IW-1:0] cfg_addr = '0;
  logic [W-1:0]  cfg_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_value = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          out_hit;
  logic [IW-1:0] out_index;
  logic          out_multi;
  logic [CW-1:0] multi_count;

  value_match_classifier #(.WIDTH(W), .NUM_ENTRIES(N), .IDX_W(IW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .in_valid(in_valid), .in_ready(in_ready), .in_value(in_value),
    .out_valid(out_valid), .out_ready(out_ready), .out_hit(out_hit),
    .out_index(out_index), .out_multi(out_multi), .multi_count(multi_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {logic hit; logic [IW-1:0] idx; logic multi; int rdy;} res_t;
  typedef struct {logic hit; logic [IW-1:0] idx; logic multi;} pop_t;

  res_t         mq[$];
  pop_t         popped[$];
  logic [W-1:0] mtab [N];
  int           mcount = 0;
  int           cyc = 0;
  bit           verbose = 1'b1;

  logic          p_rst = 1'b0;
  logic          p_in_valid = 1'b0;
  logic [W-1:0]  p_in_value = '0;
  logic          p_cfg_we = 1'b0;
  logic [IW-1:0] p_cfg_addr = '0;
  logic [W-1:0]  p_cfg_data = '0;
  logic          p_out_ready = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < N; i++) mtab[i] = W'(i + 1);
    mq.delete();
    mcount = 0;
  endfunction

  // Classify a value against the model table: first match, match count.
  function automatic res_t classify(input logic [W-1:0] v, input int rdy);
    res_t r;
    int   n;
    n = 0;
    r.hit = 1'b0; r.idx = '0; r.multi = 1'b0; r.rdy = rdy;
    for (int i = 0; i < N; i++) begin
      if (v == mtab[i]) begin
        if (n == 0) r.idx = IW'(i);
        n++;
      end
    end
    r.hit = (n > 0);
    r.multi = (n >= 2);
    return r;
  endfunction

  // Model update for the edge just passed, then compare every output.
  always @(negedge clk) begin
    bit   acc;
    bit   exp_valid;
    res_t r;
    cyc++;
    if (p_rst) begin
      acc = p_in_valid && ((mq.size() < 2) || p_out_ready);
      if (mq.size() > 0 && mq[0].rdy <= cyc - 1 && p_out_ready) begin
        if (mq[0].multi && mcount < (1 << CW) - 1) mcount++;
        void'(mq.pop_front());
      end
      if (acc) begin
        r = classify(p_in_value, cyc + 1);
        mq.push_back(r);
      end
      if (p_cfg_we && p_cfg_addr < IW'(N)) mtab[p_cfg_addr] = p_cfg_data;
    end
    if (!rst_n) begin
      model_reset();
      check("reset_out_valid", out_valid, 0);
      check("reset_out_hit", out_hit, 0);
      check("reset_out_index", out_index, 0);
      check("reset_out_multi", out_multi, 0);
      check("reset_multi_count", multi_count, 0);
    end else begin
      exp_valid = (mq.size() > 0) && (cyc >= mq[0].rdy);
      check("out_valid", out_valid, exp_valid);
      check("in_ready", in_ready, (mq.size() < 2) || out_ready);
      check("multi_count", multi_count, mcount);
      if (exp_valid) begin
        check("out_hit", out_hit, mq[0].hit);
        check("out_index", out_index, mq[0].idx);
        check("out_multi", out_multi, mq[0].multi);
      end
      if (out_valid && out_ready) begin
        popped.push_back('{hit: out_hit, idx: out_index, multi: out_multi});
        if (verbose)
          $display("result t=%0t hit=%0d index=%0d multi=%0d count=%0d",
                   $time, out_hit, out_index, out_multi, multi_count);
      end
    end
    p_rst = rst_n; p_in_valid = in_valid; p_in_value = in_value;
    p_cfg_we = cfg_we; p_cfg_addr = cfg_addr; p_cfg_data = cfg_data;
    p_out_ready = out_ready;
  end

  // All driver tasks start and end at posedge+1.
  task automatic wait_accept();
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      errors++;
      $display("FAIL accept_timeout actual=stalled required=accepted at t=%0t", $time);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_value = $urandom;
  endtask

  task automatic send(input logic [W-1:0] v);
    in_valid = 1'b1;
    in_value = v;
    wait_accept();
  endtask

  task automatic cfg_write(input logic [IW-1:0] a, input logic [W-1:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    @(negedge clk);
    while (mq.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) begin
      errors++;
      $display("FAIL drain_timeout actual=%0d required=0 in flight", mq.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic expect_pops(input int cnt);
    int n;
    n = 0;
    while (popped.size() < cnt && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (popped.size() < cnt) begin
      errors++;
      $display("FAIL pop_timeout actual=%0d required=%0d results", popped.size(), cnt);
    end
    @(posedge clk); #1;
  endtask

  task automatic pin(input string name, input int k, input logic h, input int idx, input logic m);
    if (k < popped.size()) begin
      check({name, "_hit"}, popped[k].hit, h);
      check({name, "_index"}, popped[k].idx, idx);
      check({name, "_multi"}, popped[k].multi, m);
    end else begin
      errors++;
      $display("FAIL %s_missing actual=none required=result %0d", name, k);
    end
  endtask

  task automatic reset_dut();
    rst_n = 1'b0; in_valid = 1'b0; cfg_we = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_in_ready", in_ready, 1);
    check("post_reset_out_valid", out_valid, 0);
    check("post_reset_count", multi_count, 0);
    @(posedge clk); #1;

    // Default table stream.
    popped.delete();
    send(1); send(5); send(12); send(19);
    expect_pops(4);
    pin("stream1", 0, 1, 0, 0);
    pin("stream5", 1, 1, 4, 0);
    pin("stream12", 2, 1, 11, 0);
    pin("stream19", 3, 0, 0, 0);
    drain();

    // Duplicate constant -> multiple match.
    cfg_write(7, 3);
    popped.delete();
    send(3); send(8);
    expect_pops(2);
    pin("dup3", 0, 1, 2, 1);
    pin("val8", 1, 0, 0, 0);
    drain();
    @(negedge clk);
    check("count_after_dup", multi_count, 1);
    @(posedge clk); #1;

    // Backpressure: two accepted, third stalls, outputs hold.
    popped.delete();
    out_ready = 1'b0;
    send(1); send(2);
    in_valid = 1'b1; in_value = 3;
    repeat (3) begin
      @(negedge clk);
      check("bp_in_ready", in_ready, 0);
      check("bp_out_valid", out_valid, 1);
      check("bp_hold_index", out_index, 0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_accept();
    expect_pops(3);
    pin("bp1", 0, 1, 0, 0);
    pin("bp2", 1, 1, 1, 0);
    pin("bp3", 2, 1, 2, 1);
    drain();

    // Write on the same edge that accepts a matching value.
    popped.delete();
    cfg_we = 1'b1; cfg_addr = 0; cfg_data = 9;
    in_valid = 1'b1; in_value = 1;
    wait_accept();
    cfg_we = 1'b0;
    send(1); send(9);
    expect_pops(3);
    pin("same_edge", 0, 1, 0, 0);
    pin("after_write1", 1, 0, 0, 0);
    pin("after_write9", 2, 1, 0, 1);
    drain();

    // Out-of-range writes are ignored.
    reset_dut();
    cfg_write(13, 7);
    cfg_write(15, 1);
    popped.delete();
    for (int v = 1; v <= N; v++) send(W'(v));
    expect_pops(N);
    for (int v = 1; v <= N; v++) pin("oor", v - 1, 1, v - 1, 0);
    drain();

    // Randomized traffic, writes and backpressure.
    for (int i = 0; i < 1500; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_value  = ($urandom_range(0, 2) == 0) ? W'($urandom) : W'($urandom_range(0, 20));
      out_ready = ($urandom_range(0, 3) != 0);
      cfg_we    = ($urandom_range(0, 15) == 0);
      cfg_addr  = IW'($urandom_range(0, 15));
      cfg_data  = W'($urandom_range(1, 20));
      @(posedge clk); #1;
    end
    in_valid = 1'b0; cfg_we = 1'b0; out_ready = 1'b1;
    drain();

    // Counter saturation, then asynchronous reset mid-stream.
    reset_dut();
    cfg_write(1, 1);
    verbose = 1'b0;
    in_valid = 1'b1; in_value = 1; out_ready = 1'b1;
    n = 0;
    while (mcount < (1 << CW) - 1 && n < 70000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 70000) begin
      errors++;
      $display("FAIL saturate_timeout actual=%0d required=%0d", mcount, (1 << CW) - 1);
    end
    repeat (5) @(negedge clk);
    check("count_saturated", multi_count, 65535);
    check("stream_out_valid", out_valid, 1);
    @(posedge clk); #1;
    rst_n = 1'b0; in_valid = 1'b0;
    #2;
    check("async_rst_out_valid", out_valid, 0);
    check("async_rst_count", multi_count, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    verbose = 1'b1;
    popped.delete();
    for (int v = 1; v <= N; v++) send(W'(v));
    expect_pops(N);
    for (int v = 1; v <= N; v++) pin("post_rst", v - 1, 1, v - 1, 0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
